// File: rtl/bme280_sequencer.sv
// BME280 sequencer: resets and configures the sensor over I2C, then polls a register burst into a bank.
// Define BME280_ID_CHECK_EN to insert a chip-ID read (0xD0 == 0x60) between configuration and polling.
module bme280_sequencer #(
  parameter logic [6:0]  SLAVE_ADDRESS  = 7'h76,
  parameter logic [7:0]  BASE_REG       = 8'hF7,
  parameter int          BURST_LEN      = 8,
  parameter logic [7:0]  CTRL_HUM_VAL   = 8'h01,
  parameter logic [7:0]  CTRL_MEAS_VAL  = 8'h27,
  parameter logic [7:0]  CONFIG_VAL     = 8'h00,
  parameter logic [15:0] RESET_WAIT     = 16'd20000,
  parameter logic [23:0] POLL_CYCLES    = 24'd1000000,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       i2c_en,
  output logic [6:0] i2c_slave_address,
  output logic       i2c_read_write,
  output logic [7:0] i2c_register_address,
  output logic [7:0] i2c_data_in,
  input  logic [7:0] i2c_data_out,
  input  logic       i2c_done,
  input  logic [3:0] register_selector,
  output logic [7:0] data,
  output logic       sample_valid,
  output logic       busy,
  output logic       error
);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    WR_RESET   = 4'd1,
    WAIT_RESET = 4'd2,
    WR_HUM     = 4'd3,
    WR_MEAS    = 4'd4,
    WR_CONFIG  = 4'd5,
`ifdef BME280_ID_CHECK_EN
    CHK_ID     = 4'd6,
`endif
    RD_BURST   = 4'd7,
    COMMIT     = 4'd8,
    POLL_WAIT  = 4'd9
  } state_t;

  localparam logic [3:0]  LP_LAST_K     = 4'(BURST_LEN - 1);
  localparam logic [4:0]  LP_LEN        = 5'(BURST_LEN);
  localparam logic [23:0] LP_RESET_LAST = {8'd0, RESET_WAIT} - 24'd1;
  localparam logic [23:0] LP_POLL_LAST  = POLL_CYCLES - 24'd1;
  localparam logic [23:0] LP_TO_LAST    = {4'd0, TIMEOUT_CYCLES} - 24'd1;
`ifdef BME280_ID_CHECK_EN
  localparam logic [7:0]  LP_CHIP_ID    = 8'h60;
`endif

  // r_active splits each transaction state into a setup cycle (fields out, en low) and a request phase.
  state_t      r_state, w_state_next, w_after;
  logic        r_active, w_active_next;
  logic [23:0] r_cnt, w_cnt_next;
  logic [3:0]  r_k, w_k_next;
  logic        r_error, w_error_next;
  logic        w_capture, w_commit;

  logic        r_en, w_en_next;
  logic [6:0]  r_addr, w_addr_next;
  logic        r_rw, w_rw_next;
  logic [7:0]  r_reg, w_reg_next;
  logic [7:0]  r_din, w_din_next;
  logic        r_busy, r_sample_valid;
  logic [7:0]  r_data;
  logic [7:0]  r_shadow [0:15];
  logic [7:0]  r_bank   [0:15];

  function automatic logic f_is_txn(input state_t s);
    case (s)
      WR_RESET, WR_HUM, WR_MEAS, WR_CONFIG,
`ifdef BME280_ID_CHECK_EN
      CHK_ID,
`endif
      RD_BURST: f_is_txn = 1'b1;
      default:  f_is_txn = 1'b0;
    endcase
  endfunction

  // State register together with the shared cycle counter, burst index and sticky fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_active <= 1'b0;
      r_cnt    <= 24'd0;
      r_k      <= 4'd0;
      r_error  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_active <= w_active_next;
      r_cnt    <= w_cnt_next;
      r_k      <= w_k_next;
      r_error  <= w_error_next;
    end
  end

  // Next-state logic; a done pulse coinciding with timeout expiry is treated as completion.
  always_comb begin
    w_state_next  = r_state;
    w_active_next = r_active;
    w_cnt_next    = r_cnt;
    w_k_next      = r_k;
    w_error_next  = r_error;
    w_after       = IDLE;
    w_capture     = 1'b0;
    w_commit      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !r_error) begin
          w_state_next  = WR_RESET;
          w_active_next = 1'b0;
          w_cnt_next    = 24'd0;
        end else begin
          w_state_next = IDLE;
        end
      end
      WAIT_RESET: begin
        if (!start) begin
          w_state_next = IDLE;
        end else if (r_cnt == LP_RESET_LAST) begin
          w_state_next  = WR_HUM;
          w_active_next = 1'b0;
          w_cnt_next    = 24'd0;
        end else begin
          w_cnt_next = r_cnt + 24'd1;
        end
      end
      COMMIT: begin
        w_commit     = 1'b1;
        w_cnt_next   = 24'd0;
        w_state_next = start ? POLL_WAIT : IDLE;
      end
      POLL_WAIT: begin
        if (!start) begin
          w_state_next = IDLE;
        end else if (r_cnt == LP_POLL_LAST) begin
          w_state_next  = RD_BURST;
          w_active_next = 1'b0;
          w_cnt_next    = 24'd0;
          w_k_next      = 4'd0;
        end else begin
          w_cnt_next = r_cnt + 24'd1;
        end
      end
      WR_RESET, WR_HUM, WR_MEAS, WR_CONFIG,
`ifdef BME280_ID_CHECK_EN
      CHK_ID,
`endif
      RD_BURST: begin
        if (!r_active) begin
          if (start) begin
            w_active_next = 1'b1;
            w_cnt_next    = 24'd0;
          end else begin
            w_state_next = IDLE;
          end
        end else if (i2c_done) begin
          w_active_next = 1'b0;
          w_cnt_next    = 24'd0;
          case (r_state)
            WR_RESET: w_after = WAIT_RESET;
            WR_HUM:   w_after = WR_MEAS;
            WR_MEAS:  w_after = WR_CONFIG;
            WR_CONFIG: begin
`ifdef BME280_ID_CHECK_EN
              w_after  = CHK_ID;
`else
              w_after  = RD_BURST;
`endif
              w_k_next = 4'd0;
            end
`ifdef BME280_ID_CHECK_EN
            CHK_ID: begin
              if (i2c_data_out == LP_CHIP_ID) begin
                w_after = RD_BURST;
              end else begin
                w_after      = IDLE;
                w_error_next = 1'b1;
              end
              w_k_next = 4'd0;
            end
`endif
            RD_BURST: begin
              w_capture = 1'b1;
              if (r_k == LP_LAST_K) begin
                w_after = COMMIT;
              end else begin
                w_after  = RD_BURST;
                w_k_next = r_k + 4'd1;
              end
            end
            default: w_after = IDLE;
          endcase
          w_state_next = start ? w_after : IDLE;
        end else if (r_cnt == LP_TO_LAST) begin
          w_state_next  = IDLE;
          w_active_next = 1'b0;
          w_cnt_next    = 24'd0;
          w_error_next  = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 24'd1;
        end
      end
      default: begin
        w_state_next  = IDLE;
        w_active_next = 1'b0;
      end
    endcase
  end

  // Transaction fields derived from the upcoming state so they are registered a cycle before en.
  always_comb begin
    w_rw_next  = 1'b0;
    w_reg_next = 8'h00;
    w_din_next = 8'h00;
    case (w_state_next)
      WR_RESET:  begin w_reg_next = 8'hE0; w_din_next = 8'hB6;         end
      WR_HUM:    begin w_reg_next = 8'hF2; w_din_next = CTRL_HUM_VAL;  end
      WR_MEAS:   begin w_reg_next = 8'hF4; w_din_next = CTRL_MEAS_VAL; end
      WR_CONFIG: begin w_reg_next = 8'hF5; w_din_next = CONFIG_VAL;    end
`ifdef BME280_ID_CHECK_EN
      CHK_ID:    begin w_rw_next = 1'b1; w_reg_next = 8'hD0;           end
`endif
      RD_BURST:  begin w_rw_next = 1'b1; w_reg_next = BASE_REG + {4'd0, w_k_next}; end
      default:   begin w_rw_next = 1'b0; end
    endcase
    if (f_is_txn(w_state_next)) begin
      w_addr_next = SLAVE_ADDRESS;
      w_en_next   = w_active_next;
    end else begin
      w_addr_next = 7'd0;
      w_en_next   = 1'b0;
    end
  end

  // Registered I2C request, status flags, shadow capture and atomic bank commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en           <= 1'b0;
      r_addr         <= 7'd0;
      r_rw           <= 1'b0;
      r_reg          <= 8'h00;
      r_din          <= 8'h00;
      r_busy         <= 1'b0;
      r_sample_valid <= 1'b0;
      r_data         <= 8'h00;
      for (int i = 0; i < 16; i++) begin
        r_shadow[i] <= 8'h00;
        r_bank[i]   <= 8'h00;
      end
    end else begin
      r_en           <= w_en_next;
      r_addr         <= w_addr_next;
      r_rw           <= w_rw_next;
      r_reg          <= w_reg_next;
      r_din          <= w_din_next;
      r_busy         <= (w_state_next != IDLE);
      r_sample_valid <= w_commit;
      r_data         <= ({1'b0, register_selector} < LP_LEN) ? r_bank[register_selector] : 8'h00;
      if (w_capture) begin
        r_shadow[r_k] <= i2c_data_out;
      end
      if (w_commit) begin
        r_bank <= r_shadow;
      end
    end
  end

  assign i2c_en               = r_en;
  assign i2c_slave_address    = r_addr;
  assign i2c_read_write       = r_rw;
  assign i2c_register_address = r_reg;
  assign i2c_data_in          = r_din;
  assign data                 = r_data;
  assign sample_valid         = r_sample_valid;
  assign busy                 = r_busy;
  assign error                = r_error;

endmodule

// File: tb/tb_bme280_sequencer.sv
// Scoreboard bench for bme280_sequencer: two instances (default burst and a wrapping 3-byte burst)
// driven by a slave model that acks every request four cycles after i2c_en rises.
`timescale 1ns/1ps
module tb_bme280_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [7:0] BASE_A = 8'hF7;
  localparam logic [7:0] BASE_B = 8'hFE;

  logic       rst_i [2];
  logic       start_i [2];
  logic       done_i [2];
  logic [7:0] dout_i [2];
  logic [3:0] sel_i [2];
  logic       en_o [2];
  logic       rw_o [2];
  logic       sv_o [2];
  logic       busy_o [2];
  logic       err_o [2];
  logic [6:0] addr_o [2];
  logic [7:0] reg_o [2];
  logic [7:0] din_o [2];
  logic [7:0] data_o [2];

  bme280_sequencer #(.BASE_REG(BASE_A), .BURST_LEN(8), .RESET_WAIT(16'd10),
                     .POLL_CYCLES(24'd40), .TIMEOUT_CYCLES(20'd50)) dut_a (
    .clk(clk), .rst(rst_i[0]), .start(start_i[0]), .i2c_en(en_o[0]),
    .i2c_slave_address(addr_o[0]), .i2c_read_write(rw_o[0]),
    .i2c_register_address(reg_o[0]), .i2c_data_in(din_o[0]),
    .i2c_data_out(dout_i[0]), .i2c_done(done_i[0]), .register_selector(sel_i[0]),
    .data(data_o[0]), .sample_valid(sv_o[0]), .busy(busy_o[0]), .error(err_o[0]));

  bme280_sequencer #(.BASE_REG(BASE_B), .BURST_LEN(3), .RESET_WAIT(16'd10),
                     .POLL_CYCLES(24'd40), .TIMEOUT_CYCLES(20'd50)) dut_b (
    .clk(clk), .rst(rst_i[1]), .start(start_i[1]), .i2c_en(en_o[1]),
    .i2c_slave_address(addr_o[1]), .i2c_read_write(rw_o[1]),
    .i2c_register_address(reg_o[1]), .i2c_data_in(din_o[1]),
    .i2c_data_out(dout_i[1]), .i2c_done(done_i[1]), .register_selector(sel_i[1]),
    .data(data_o[1]), .sample_valid(sv_o[1]), .busy(busy_o[1]), .error(err_o[1]));

  int n_tests = 0;
  int n_fail  = 0;

  logic [16:0] exp_q0 [$];
  logic [16:0] exp_q1 [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input int g, input logic rw, input logic [7:0] r, input logic [7:0] d);
    if (g == 0) exp_q0.push_back({rw, r, d});
    else        exp_q1.push_back({rw, r, d});
  endtask

  task automatic push_init(input int g);
    push_exp(g, 1'b0, 8'hE0, 8'hB6);
    push_exp(g, 1'b0, 8'hF2, 8'h01);
    push_exp(g, 1'b0, 8'hF4, 8'h27);
    push_exp(g, 1'b0, 8'hF5, 8'h00);
`ifdef BME280_ID_CHECK_EN
    push_exp(g, 1'b1, 8'hD0, 8'h00);
`endif
  endtask

  task automatic push_reads(input int g, input logic [7:0] base, input int n);
    for (int k = 0; k < n; k++) push_exp(g, 1'b1, base + 8'(k), 8'h00);
  endtask

  function automatic int exp_size(input int g);
    return (g == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [16:0] pop_exp(input int g);
    if (g == 0) return exp_q0.pop_front();
    else        return exp_q1.pop_front();
  endfunction

  // Slave model: one-cycle done pulse on the fourth negedge after a request is seen.
  int         pend [2];
  logic       silent [2];
  logic [7:0] rd_base [2];
  logic [7:0] id_val [2];
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      done_i[g] = 1'b0;
      if (silent[g]) begin
        pend[g] = 0;
      end else if (pend[g] == 0) begin
        if (en_o[g]) pend[g] = 1;
      end else if (pend[g] == 3) begin
        pend[g]   = 0;
        done_i[g] = 1'b1;
        if (reg_o[g] == 8'hD0) dout_i[g] = id_val[g];
        else dout_i[g] = rd_base[g] + (reg_o[g] - ((g == 0) ? BASE_A : BASE_B));
      end else begin
        pend[g] = pend[g] + 1;
      end
    end
  end

  // Monitor: every rising i2c_en pops the scoreboard; sample_valid pulses are counted.
  logic        en_prev [2];
  logic [16:0] fld_prev [2];
  logic [16:0] mon_act;
  int          sv_cnt [2];
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (sv_o[g]) sv_cnt[g] = sv_cnt[g] + 1;
      if (en_o[g] && !en_prev[g]) begin
        mon_act = {rw_o[g], reg_o[g], din_o[g]};
        check($sformatf("txn_setup_stable%0d", g), mon_act, fld_prev[g]);
        check($sformatf("txn_addr%0d", g), addr_o[g], 7'h76);
        if (exp_size(g) == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL txn_unexpected%0d: got %0h, expected no request", g, mon_act);
        end else begin
          check($sformatf("txn_order%0d", g), mon_act, pop_exp(g));
        end
      end
      en_prev[g]  = en_o[g];
      fld_prev[g] = {rw_o[g], reg_o[g], din_o[g]};
    end
  end

  task automatic sel_check(input int g, input logic [3:0] s, input logic [7:0] exp, input string name);
    sel_i[g] = s;
    @(negedge clk);
    check(name, data_o[g], exp);
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      rst_i[g] = 1'b1; start_i[g] = 1'b0; sel_i[g] = 4'd0;
      done_i[g] = 1'b0; dout_i[g] = 8'h00; silent[g] = 1'b0;
      rd_base[g] = 8'h10; id_val[g] = 8'h60; pend[g] = 0;
      sv_cnt[g] = 0; en_prev[g] = 1'b0; fld_prev[g] = 17'd0;
    end
    repeat (3) @(negedge clk);
    check("rst_en", en_o[0], 1'b0);
    check("rst_busy", busy_o[0], 1'b0);
    check("rst_error", err_o[0], 1'b0);
    check("rst_data", data_o[0], 8'h00);
    check("rst_fields", {addr_o[0], reg_o[0], din_o[0]}, 23'd0);
    rst_i[0] = 1'b0; rst_i[1] = 1'b0;

    // Nominal init + first burst on both instances.
    push_init(0); push_reads(0, BASE_A, 8);
    push_init(1); push_reads(1, BASE_B, 3);
    start_i[0] = 1'b1; start_i[1] = 1'b1;
    repeat (2) @(negedge clk);
    check("busy_run", busy_o[0], 1'b1);
    for (int i = 0; i < 400 && sv_cnt[1] == 0; i++) @(negedge clk);
    check("b_sample", sv_cnt[1], 1);
    start_i[1] = 1'b0;
    for (int i = 0; i < 400 && sv_cnt[0] == 0; i++) @(negedge clk);
    check("a_sample", sv_cnt[0], 1);
    rd_base[0] = 8'h80;
    push_reads(0, BASE_A, 5);
    sel_check(0, 4'd3, 8'h13, "a_sel3");
    sel_check(0, 4'd0, 8'h10, "a_sel0");
    sel_check(0, 4'd7, 8'h17, "a_sel7");
    sel_check(0, 4'd8, 8'h00, "a_sel8_oob");
    sel_check(0, 4'd15, 8'h00, "a_sel15_oob");
    check("b_idle", busy_o[1], 1'b0);
    sel_check(1, 4'd0, 8'h10, "b_sel0");
    sel_check(1, 4'd2, 8'h12, "b_sel2_wrap");
    sel_check(1, 4'd5, 8'h00, "b_sel5_oob");

    // Drop start while the k=4 read of the second burst is in flight.
    for (int i = 0; i < 200 && !(en_o[0] && reg_o[0] == 8'hFB); i++) @(negedge clk);
    check("a_k4_reached", {en_o[0], reg_o[0]}, {1'b1, 8'hFB});
    start_i[0] = 1'b0;
    for (int i = 0; i < 50 && busy_o[0]; i++) @(negedge clk);
    check("drop_idle", busy_o[0], 1'b0);
    check("drop_queue", exp_size(0), 0);
    check("drop_no_sv", sv_cnt[0], 1);
    sel_check(0, 4'd4, 8'h14, "drop_old4");
    sel_check(0, 4'd0, 8'h10, "drop_old0");

    // Reset in the middle of the WR_MEAS request.
    sel_i[0] = 4'd4;
    push_exp(0, 1'b0, 8'hE0, 8'hB6);
    push_exp(0, 1'b0, 8'hF2, 8'h01);
    push_exp(0, 1'b0, 8'hF4, 8'h27);
    start_i[0] = 1'b1;
    for (int i = 0; i < 300 && !(en_o[0] && reg_o[0] == 8'hF4); i++) @(negedge clk);
    check("meas_reached", {en_o[0], reg_o[0]}, {1'b1, 8'hF4});
    rst_i[0] = 1'b1; start_i[0] = 1'b0;
    @(negedge clk);
    check("rstmid_en", en_o[0], 1'b0);
    check("rstmid_busy", busy_o[0], 1'b0);
    check("rstmid_data", data_o[0], 8'h00);
    rst_i[0] = 1'b0;
    repeat (8) @(negedge clk);

    // Timeout with a silent slave.
    silent[0] = 1'b1;
    push_exp(0, 1'b0, 8'hE0, 8'hB6);
    start_i[0] = 1'b1;
    for (int i = 0; i < 20 && !en_o[0]; i++) @(negedge clk);
    check("to_req", en_o[0], 1'b1);
    repeat (49) @(negedge clk);
    check("to_pre_en", en_o[0], 1'b1);
    check("to_pre_err", err_o[0], 1'b0);
    @(negedge clk);
    check("to_err", err_o[0], 1'b1);
    check("to_en", en_o[0], 1'b0);
    repeat (20) @(negedge clk);
    check("to_no_restart", busy_o[0], 1'b0);
    check("to_sticky", err_o[0], 1'b1);
    start_i[0] = 1'b0; rst_i[0] = 1'b1;
    @(negedge clk);
    rst_i[0] = 1'b0;
    check("to_rst_clear", err_o[0], 1'b0);

`ifdef BME280_ID_CHECK_EN
    // Wrong chip ID stops the sequence before any burst read.
    silent[0] = 1'b0; id_val[0] = 8'h58;
    push_init(0);
    start_i[0] = 1'b1;
    for (int i = 0; i < 300 && !err_o[0]; i++) @(negedge clk);
    check("id_err", err_o[0], 1'b1);
    repeat (20) @(negedge clk);
    check("id_idle", busy_o[0], 1'b0);
    check("id_queue", exp_size(0), 0);
    start_i[0] = 1'b0;
`endif

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
